ntt_ctrl: RTL and testbench
===========================

Name: ntt_ctrl

Overview:
Sequencer for the NTT/INTT datapath. It walks all log2(N) stages of an in-place radix-2 transform over an N-coefficient RAM and issues one butterfly pair per cycle. For each pair it drives the read addresses, the twiddle ROM index and the butterfly mode selects, and it drives the matching write-back addresses after a fixed pipeline latency. It sits between the top-level start/done handshake and the coefficient RAM / twiddle ROM / butterfly datapath.

Parameters:
LOG_N, 8, log2 of coefficient count (N = 256); address width of RAM and twiddle ROM.
LAT, 2, cycles from read-address issue to write-back of the same pair (RAM read + butterfly + output register); legal range 1..15.

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start request; sampled only in IDLE
inverse_i  in  1  0 = forward NTT (CT butterflies), 1 = inverse (GS butterflies); latched on start
red_i  in  1  reduction select for the butterfly; latched on start
busy_o  out  1  high from the cycle after start is accepted until DONE is left
done_o  out  1  one-cycle pulse when the last write-back has been issued
rd_en_o  out  1  read/issue strobe for the current pair
rd_addr_a_o  out  LOG_N  address of the upper coefficient
rd_addr_b_o  out  LOG_N  address of the lower coefficient (rd_addr_a_o + len)
tw_addr_o  out  LOG_N  twiddle ROM index for the current pair
sel_butterfly_o  out  1  latched inverse_i, held constant for the whole run
sel_red_o  out  1  latched red_i, held constant for the whole run
wr_en_o  out  1  rd_en_o delayed by LAT cycles
wr_addr_a_o  out  LOG_N  rd_addr_a_o delayed by LAT cycles
wr_addr_b_o  out  LOG_N  rd_addr_b_o delayed by LAT cycles
stage_o  out  ceil(log2(LOG_N))  current stage s, 0..LOG_N-1

Behaviour:
- Reset: state IDLE; every output 0, including the delay-line contents (wr_en_o = 0 for LAT cycles after reset is released). A reset asserted mid-run aborts immediately; no further writes are issued.
- States:
  - IDLE: if start_i, latch mode bits, clear s and c, go to RUN.
  - RUN: rd_en_o = 1 every cycle. When c = N/2-1, go to DRAIN; otherwise c++.
  - DRAIN: count exactly LAT cycles. Then, if s = LOG_N-1, go to DONE; else s++, c = 0, go to RUN.
  - DONE: done_o = 1 for this one cycle, then go to IDLE.
- start_i is ignored outside IDLE, including the DONE cycle.
- Butterfly counter c runs 0..N/2-1 within a stage.
- Forward stage s: len = N >> (s+1).
- Inverse stage s: len = 1 << s.
- Pair addressing, with g = c >> log2(len) and j = c & (len-1):
  - rd_addr_a_o = 2·g·len + j
  - rd_addr_b_o = rd_addr_a_o + len
- Twiddle index:
  - forward: tw_addr_o = 2^s + g, covering 1..255 over the run
  - inverse: tw_addr_o = 2^(LOG_N-s) - 1 - g, giving 255 down to 1
  - Sign handling for the inverse is done inside the butterfly via sel_butterfly_o.
- Address outputs are registered and valid only while rd_en_o = 1; they are 0 otherwise.
- Stage hazard: the DRAIN length guarantees that the last write of stage s lands at least one cycle before the first read of stage s+1.
- Timing, with start accepted in cycle 0:
  - first issue in cycle 1
  - each stage takes N/2 + LAT cycles
  - done_o in cycle 1 + LOG_N·(N/2 + LAT)
  - with the defaults, done_o in cycle 1041 and exactly 1024 wr_en_o pulses
- Final N^-1 scaling for the inverse is out of scope.

Decomposition:
- Shared ntt_pkg holds:
  - LOG_N and N
  - Q = 8380417
  - state enum {IDLE, RUN, DRAIN, DONE}
  - function computing tw index from (s, g, inverse)
- Sub-module ntt_addr_delay: LAT-deep shift register carrying {wr_en, addr_a, addr_b}, with synchronous clear on rst_i.

Test Plan:
- Forward, defaults, start in cycle 0 -> cycle 1: (a,b,tw) = (0,128,1); cycle 2: (1,129,1); cycle 131 (stage 1, c=0): (0,64,2); stage 1 at c=64: (128,192,3); done_o in cycle 1041 only.
- Inverse -> stage 0 issues (0,1,255), (2,3,254); stage 7 issues (0,128,1) through (127,255,1); sel_butterfly_o = 1 throughout.
- Write-back check -> every wr_addr pair equals the rd pair from LAT cycles earlier; 1024 wr_en_o pulses in total; no rd of stage s+1 in the cycle of, or before, the last wr of stage s.
- start_i held high during the run and in the DONE cycle -> no restart and no address perturbation; start_i in the first IDLE cycle after DONE -> new run with first issue 1 cycle later.
- rst_i asserted for 1 cycle at stage 3, c=17 -> next cycle all outputs 0 and busy_o = 0; wr_en_o stays 0 (delay line flushed); subsequent start gives a clean full run.
- LAT = 1 and LAT = 5 builds -> done_o in cycles 1033 and 1065 respectively.

Source files
------------

// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared constants, FSM state encoding and twiddle-index helper
//                for the NTT/INTT sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

    localparam int LOG_N = 8;
    localparam int N     = 1 << LOG_N;
    localparam int Q     = 8380417;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Forward (CT) walks the twiddle table upwards from 2^s; inverse (GS)
    // walks it downwards from 2^(LOG_N-s)-1, so the two runs cover 1..N-1
    // in opposite orders. The caller truncates to the ROM address width.
    function automatic int tw_index(input int s, input int g, input logic inverse,
                                    input int log_n);
        if (inverse) begin
            return (1 << (log_n - s)) - 1 - g;
        end
        return (1 << s) + g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_addr_delay.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_addr_delay
//  Description : LAT-deep shift register carrying the write strobe and the
//                pair addresses from issue to write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_addr_delay #(
    parameter int WIDTH = 17,
    parameter int LAT   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_pipe [LAT];

    // Shift one slot per cycle; reset empties every slot so no stale write
    // can emerge after an abort.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < LAT; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= d_i;
            for (int k = 1; k < LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign q_o = r_pipe[LAT-1];

endmodule
`default_nettype wire

// File: rtl/ntt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_ctrl
//  Description : Stage/butterfly sequencer for an in-place radix-2 NTT/INTT.
//                Issues one butterfly pair per cycle (read addresses, twiddle
//                index, mode selects) and the matching write-back addresses
//                LAT cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_ctrl #(
    parameter int LOG_N = 8,
    parameter int LAT   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     inverse_i,
    input  logic                     red_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rd_en_o,
    output logic [LOG_N-1:0]         rd_addr_a_o,
    output logic [LOG_N-1:0]         rd_addr_b_o,
    output logic [LOG_N-1:0]         tw_addr_o,
    output logic                     sel_butterfly_o,
    output logic                     sel_red_o,
    output logic                     wr_en_o,
    output logic [LOG_N-1:0]         wr_addr_a_o,
    output logic [LOG_N-1:0]         wr_addr_b_o,
    output logic [$clog2(LOG_N)-1:0] stage_o
);

    import ntt_pkg::*;

    localparam int c_N    = 1 << LOG_N;
    localparam int c_HALF = c_N / 2;
    localparam int c_CW   = LOG_N - 1;
    localparam int c_SW   = $clog2(LOG_N);
    localparam int c_DW   = 2 * LOG_N + 1;

    state_e           r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [3:0]       r_dcnt;

    logic [c_SW-1:0]  w_iss_stage;
    logic [c_CW-1:0]  w_iss_cnt;
    logic             w_iss_inv;
    logic [LOG_N-1:0] w_iss_a;
    logic [LOG_N-1:0] w_iss_b;
    logic [LOG_N-1:0] w_iss_tw;
    logic [c_DW-1:0]  w_dly_in;
    logic [c_DW-1:0]  w_dly_out;

    // Pair geometry for butterfly c of stage s. The span len is a power of
    // two, so group/offset split and the 2*g*len product reduce to shifts.
    function automatic logic [3*LOG_N-1:0] pair_addr(input logic [c_SW-1:0] s,
                                                     input logic [c_CW-1:0] c,
                                                     input logic inv);
        int               lg;
        logic [LOG_N-1:0] cx;
        logic [LOG_N-1:0] len;
        logic [LOG_N-1:0] g;
        logic [LOG_N-1:0] j;
        logic [LOG_N-1:0] a;
        logic [LOG_N-1:0] b;
        logic [LOG_N-1:0] tw;
        lg  = inv ? int'(s) : (LOG_N - 1 - int'(s));
        cx  = LOG_N'(c);
        len = LOG_N'(1) << lg;
        g   = cx >> lg;
        j   = cx & (len - LOG_N'(1));
        a   = (g << (lg + 1)) | j;
        b   = a + len;
        tw  = LOG_N'(tw_index(int'(s), int'(g), inv, LOG_N));
        return {a, b, tw};
    endfunction

    // Stage, counter and mode of the pair that will be on the outputs next
    // cycle, so the registered outputs line up with the FSM state.
    always_comb begin
        w_iss_stage = stage_o;
        w_iss_cnt   = r_cnt + c_CW'(1);
        w_iss_inv   = sel_butterfly_o;
        case (r_state)
            IDLE: begin
                w_iss_stage = '0;
                w_iss_cnt   = '0;
                w_iss_inv   = inverse_i;
            end
            DRAIN: begin
                w_iss_stage = stage_o + c_SW'(1);
                w_iss_cnt   = '0;
            end
            default: ;
        endcase
        {w_iss_a, w_iss_b, w_iss_tw} = pair_addr(w_iss_stage, w_iss_cnt, w_iss_inv);
    end

    // Sequencer FSM with registered issue outputs; DRAIN holds off the next
    // stage until the last write-back of the current one has landed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_dcnt          <= '0;
            stage_o         <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            rd_en_o         <= 1'b0;
            rd_addr_a_o     <= '0;
            rd_addr_b_o     <= '0;
            tw_addr_o       <= '0;
            sel_butterfly_o <= 1'b0;
            sel_red_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        sel_butterfly_o <= inverse_i;
                        sel_red_o       <= red_i;
                        stage_o         <= '0;
                        r_cnt           <= '0;
                        busy_o          <= 1'b1;
                        rd_en_o         <= 1'b1;
                        rd_addr_a_o     <= w_iss_a;
                        rd_addr_b_o     <= w_iss_b;
                        tw_addr_o       <= w_iss_tw;
                        r_state         <= RUN;
                    end
                end
                RUN: begin
                    if (r_cnt == c_CW'(c_HALF - 1)) begin
                        r_dcnt      <= '0;
                        rd_en_o     <= 1'b0;
                        rd_addr_a_o <= '0;
                        rd_addr_b_o <= '0;
                        tw_addr_o   <= '0;
                        r_state     <= DRAIN;
                    end else begin
                        r_cnt       <= r_cnt + c_CW'(1);
                        rd_en_o     <= 1'b1;
                        rd_addr_a_o <= w_iss_a;
                        rd_addr_b_o <= w_iss_b;
                        tw_addr_o   <= w_iss_tw;
                    end
                end
                DRAIN: begin
                    if (r_dcnt == 4'(LAT - 1)) begin
                        if (stage_o == c_SW'(LOG_N - 1)) begin
                            done_o  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            stage_o     <= stage_o + c_SW'(1);
                            r_cnt       <= '0;
                            rd_en_o     <= 1'b1;
                            rd_addr_a_o <= w_iss_a;
                            rd_addr_b_o <= w_iss_b;
                            tw_addr_o   <= w_iss_tw;
                            r_state     <= RUN;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 4'd1;
                    end
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_dly_in = {rd_en_o, rd_addr_a_o, rd_addr_b_o};

    ntt_addr_delay #(
        .WIDTH (c_DW),
        .LAT   (LAT)
    ) u_addr_delay (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (w_dly_in),
        .q_o   (w_dly_out)
    );

    assign {wr_en_o, wr_addr_a_o, wr_addr_b_o} = w_dly_out;

endmodule
`default_nettype wire

// File: tb/tb_ntt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_ctrl
//  Description : Scoreboard bench for ntt_ctrl. A loop-nest NTT reference
//                model predicts every issued pair, write-back and done pulse
//                with its cycle; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_ctrl;

    parameter int LAT = 2;

    localparam int LOG_N     = 8;
    localparam int N         = 1 << LOG_N;
    localparam int SW        = $clog2(LOG_N);
    localparam int STAGE_CYC = N / 2 + LAT;
    localparam int DONE_OFS  = 1 + LOG_N * STAGE_CYC;
    localparam int MAXC      = 16384;

    logic             clk;
    logic             rst_i;
    logic             start_i;
    logic             inverse_i;
    logic             red_i;
    logic             busy_o;
    logic             done_o;
    logic             rd_en_o;
    logic [LOG_N-1:0] rd_addr_a_o;
    logic [LOG_N-1:0] rd_addr_b_o;
    logic [LOG_N-1:0] tw_addr_o;
    logic             sel_butterfly_o;
    logic             sel_red_o;
    logic             wr_en_o;
    logic [LOG_N-1:0] wr_addr_a_o;
    logic [LOG_N-1:0] wr_addr_b_o;
    logic [SW-1:0]    stage_o;

    ntt_ctrl #(
        .LOG_N (LOG_N),
        .LAT   (LAT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .inverse_i       (inverse_i),
        .red_i           (red_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .rd_en_o         (rd_en_o),
        .rd_addr_a_o     (rd_addr_a_o),
        .rd_addr_b_o     (rd_addr_b_o),
        .tw_addr_o       (tw_addr_o),
        .sel_butterfly_o (sel_butterfly_o),
        .sel_red_o       (sel_red_o),
        .wr_en_o         (wr_en_o),
        .wr_addr_a_o     (wr_addr_a_o),
        .wr_addr_b_o     (wr_addr_b_o),
        .stage_o         (stage_o)
    );

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
        bit inv;
        bit red;
    } rd_t;

    typedef struct {
        int cyc;
        int a;
        int b;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  done_q[$];
    bit  exp_busy [MAXC];

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: textbook CT (forward) / GS (inverse) loop nest with a running
    // twiddle pointer; issue k of stage st is expected at s0+1+st*STAGE_CYC+k.
    // abort >= 0 keeps only events up to and including that cycle.
    task automatic plan_run(input int s0, input bit inv, input bit red, input int abort);
        int  k;
        int  len;
        int  idx;
        int  t_rd;
        int  tw;
        int  last;
        rd_t r;
        wr_t w;
        k = inv ? N : 1;
        for (int st = 0; st < LOG_N; st++) begin
            len = inv ? (1 << st) : (N >> (st + 1));
            idx = 0;
            for (int base = 0; base < N; base += 2 * len) begin
                if (inv) begin
                    k--;
                    tw = k;
                end else begin
                    tw = k;
                    k++;
                end
                for (int j = base; j < base + len; j++) begin
                    t_rd = s0 + 1 + st * STAGE_CYC + idx;
                    idx++;
                    if (abort < 0 || t_rd <= abort) begin
                        r.cyc = t_rd; r.a = j; r.b = j + len; r.tw = tw;
                        r.st = st; r.inv = inv; r.red = red;
                        rd_q.push_back(r);
                    end
                    if (abort < 0 || t_rd + LAT <= abort) begin
                        w.cyc = t_rd + LAT; w.a = j; w.b = j + len;
                        wr_q.push_back(w);
                    end
                end
            end
        end
        if (abort >= 0) begin
            last = abort;
        end else begin
            last = s0 + DONE_OFS;
            done_q.push_back(last);
        end
        for (int c = s0 + 1; c <= last; c++) begin
            if (c < MAXC) exp_busy[c] = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, cyc, 32'(rd_en_o), 0);
        chk({tag, "_rd_addr"}, cyc, 32'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}), 0);
        chk({tag, "_wr_en"}, cyc, 32'(wr_en_o), 0);
        chk({tag, "_wr_addr"}, cyc, 32'({wr_addr_a_o, wr_addr_b_o}), 0);
        chk({tag, "_done"}, cyc, 32'(done_o), 0);
        chk({tag, "_busy"}, cyc, 32'(busy_o), 0);
        chk({tag, "_sel"}, cyc, 32'({sel_butterfly_o, sel_red_o}), 0);
        chk({tag, "_stage"}, cyc, 32'(stage_o), 0);
    endtask

    // Monitor: compare every DUT-presented event against the scoreboard.
    initial begin
        rd_t r;
        wr_t w;
        int  dc;
        forever begin
            @(negedge clk);
            if (cyc < MAXC) chk("busy", cyc, 32'(busy_o), 32'(exp_busy[cyc]));
            if (rd_en_o === 1'b1) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", cyc, 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_cycle", cyc, cyc, r.cyc);
                    chk("rd_addr_a", cyc, 32'(rd_addr_a_o), r.a);
                    chk("rd_addr_b", cyc, 32'(rd_addr_b_o), r.b);
                    chk("tw_addr", cyc, 32'(tw_addr_o), r.tw);
                    chk("stage", cyc, 32'(stage_o), r.st);
                    chk("sel_butterfly", cyc, 32'(sel_butterfly_o), 32'(r.inv));
                    chk("sel_red", cyc, 32'(sel_red_o), 32'(r.red));
                end
            end else begin
                chk("rd_en_idle", cyc, 32'(rd_en_o), 0);
                chk("rd_idle_addr", cyc, 32'({rd_addr_a_o, rd_addr_b_o, tw_addr_o}), 0);
            end
            if (wr_en_o === 1'b1) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", cyc, 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_cycle", cyc, cyc, w.cyc);
                    chk("wr_addr_a", cyc, 32'(wr_addr_a_o), w.a);
                    chk("wr_addr_b", cyc, 32'(wr_addr_b_o), w.b);
                end
            end else begin
                chk("wr_en_idle", cyc, 32'(wr_en_o), 0);
            end
            if (done_o === 1'b1) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", cyc, 1, 0);
                end else begin
                    dc = done_q.pop_front();
                    chk("done_cycle", cyc, cyc, dc);
                end
            end else begin
                chk("done_idle", cyc, 32'(done_o), 0);
            end
        end
    end

    // Stimulus: back-to-back forward/inverse runs with start held high,
    // a mid-run reset abort, then a clean run with random mode bits.
    initial begin
        int s_a;
        int s_b;
        int s_c;
        int s_d;
        int r_abort;
        bit inv;
        bit red;

        rst_i     = 1'b1;
        start_i   = 1'b0;
        inverse_i = 1'b0;
        red_i     = 1'b0;
        goto(3);
        check_all_zero("reset");
        rst_i = 1'b0;

        // Forward run, start held high through the run and the DONE cycle.
        s_a = 8;
        goto(s_a);
        red       = 1'($urandom);
        inverse_i = 1'b0;
        red_i     = red;
        start_i   = 1'b1;
        plan_run(s_a, 1'b0, red, -1);
        for (int c = s_a + 1; c <= s_a + DONE_OFS; c++) begin
            goto(c);
            inverse_i = 1'($urandom);
            red_i     = 1'($urandom);
        end

        // Start still high in the first IDLE cycle after DONE: inverse restart.
        s_b = s_a + DONE_OFS + 1;
        goto(s_b);
        red       = 1'($urandom);
        inverse_i = 1'b1;
        red_i     = red;
        plan_run(s_b, 1'b1, red, -1);
        for (int c = s_b + 1; c <= s_b + DONE_OFS; c++) begin
            goto(c);
            start_i   = 1'($urandom);
            inverse_i = 1'($urandom);
            red_i     = 1'($urandom);
        end
        goto(s_b + DONE_OFS + 1);
        start_i = 1'b0;

        // Run aborted by a one-cycle reset at stage 3, c = 17.
        s_c = s_b + DONE_OFS + 1 + int'($urandom_range(1, 6));
        goto(s_c);
        inv       = 1'($urandom);
        red       = 1'($urandom);
        inverse_i = inv;
        red_i     = red;
        start_i   = 1'b1;
        r_abort   = s_c + 1 + 3 * STAGE_CYC + 17;
        plan_run(s_c, inv, red, r_abort);
        goto(s_c + 1);
        start_i = 1'b0;
        goto(r_abort);
        rst_i = 1'b1;
        goto(r_abort + 1);
        rst_i = 1'b0;
        check_all_zero("abort");

        // Clean full run after the abort.
        s_d = r_abort + 3;
        goto(s_d);
        inv       = 1'($urandom);
        red       = 1'($urandom);
        inverse_i = inv;
        red_i     = red;
        start_i   = 1'b1;
        plan_run(s_d, inv, red, -1);
        goto(s_d + 1);
        start_i = 1'b0;
        goto(s_d + DONE_OFS + LAT + 4);

        chk("rd_q_drained", cyc, 32'(rd_q.size()), 0);
        chk("wr_q_drained", cyc, 32'(wr_q.size()), 0);
        chk("done_q_drained", cyc, 32'(done_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
